lsu_split_engine: RTL

LSU_SPLIT_ENGINE -- requirements
Module: lsu_split_engine

---
 rtl/lsu_split_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_split_engine.sv
// Load/store unit access engine: turns one pipeline access into one or two
// XLEN-aligned memory beats, then returns extended load data or an error.
module lsu_split_engine #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_data,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int BYTES     = XLEN / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int CW        = OFF_W + 2;
    localparam bit NO_DOUBLE = (XLEN == 32);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t state, state_nxt;

    logic              r_is_store;
    logic              r_unsigned;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   rdata0;
    logic [XLEN-1:0]   rdata1;

    logic [CW-1:0]     in_end;
    logic              in_mis;
    logic              in_illegal;

    logic [OFF_W-1:0]  off;
    logic [CW-1:0]     n_bytes;
    logic [CW-1:0]     end_b;
    logic [CW-1:0]     sh1;
    logic              mis;
    logic [BYTES-1:0]  be0;
    logic [BYTES-1:0]  be1;
    logic [XLEN-1:0]   wdata0;
    logic [XLEN-1:0]   wdata1;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat1_addr;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   ext;
    logic              sign_bit;
    int unsigned       nbits;

    // Legality is judged on the incoming fields so the error path skips memory.
    always_comb begin
        in_end     = CW'(req_addr[OFF_W-1:0]) + (CW'(1) << req_size);
        in_mis     = in_end > CW'(BYTES);
        in_illegal = (NO_DOUBLE && (req_size == 2'b11)) || ((SPLIT_EN == 0) && in_mis);
    end

    always_comb begin
        off        = r_addr[OFF_W-1:0];
        n_bytes    = CW'(1) << r_size;
        end_b      = CW'(off) + n_bytes;
        mis        = end_b > CW'(BYTES);
        sh1        = CW'(BYTES) - CW'(off);
        beat0_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        beat1_addr = beat0_addr + ADDR_W'(BYTES);
        wdata0     = r_wdata << {off, 3'b000};
        wdata1     = r_wdata >> {sh1, 3'b000};
        for (int unsigned i = 0; i < BYTES; i++) begin
            be0[i] = (CW'(i) >= CW'(off)) && (CW'(i) < end_b);
            be1[i] = (CW'(i) + CW'(BYTES)) < end_b;
        end
    end

    // Beat1 bytes sit directly above beat0's upper lanes, so one shift aligns the access.
    always_comb begin
        raw      = XLEN'({rdata1, rdata0} >> {off, 3'b000});
        nbits    = 32'd8 << r_size;
        ext      = raw;
        sign_bit = 1'b0;
        if (n_bytes < CW'(BYTES)) begin
            case (r_size)
                2'b00:   sign_bit = raw[7];
                2'b01:   sign_bit = raw[15];
                default: sign_bit = raw[31];
            endcase
            sign_bit = sign_bit && !r_unsigned;
            for (int unsigned i = 0; i < XLEN; i++) begin
                ext[i] = (i < nbits) ? raw[i] : sign_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_err      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = in_illegal ? RESP : REQ0;
                end
            end
            REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_we    = r_is_store;
                mem_req_addr  = beat0_addr;
                mem_req_wdata = wdata0;
                mem_req_be    = be0;
                if (mem_req_ready) begin
                    state_nxt = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
                    state_nxt = mis ? REQ1 : RESP;
                end
            end
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_we    = r_is_store;
                mem_req_addr  = beat1_addr;
                mem_req_wdata = wdata1;
                mem_req_be    = be1;
                if (mem_req_ready) begin
                    state_nxt = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rsp_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_data  = (r_err || r_is_store) ? '0 : ext;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                r_is_store <= req_is_store;
                r_unsigned <= req_unsigned;
                r_err      <= in_illegal;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (state == WAIT0 && mem_rsp_valid) begin
                rdata0 <= mem_rsp_rdata;
            end
            if (state == WAIT1 && mem_rsp_valid) begin
                rdata1 <= mem_rsp_rdata;
            end
        end
    end

endmodule
